ps2_tx: RTL and testbench

Host-to-device PS/2 transmitter. Sends one command byte, for example LED set 0xED or enable 0xF4, to a keyboard or mouse over the open-drain PS2Clk/PS2Data lines. It is the send-side companion of ps2_rx and shares the same physical lines through tri-state enables at the top level. The block runs the full handshake: clock inhibit, request-to-send, bit shifting on device-generated clock edges, ack check and timeout.

---
 rtl/ps2_tx.sv | 156 +++++++++++++++
 tb/tb_ps2_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 command transmitter. Optional PS2Clk glitch filter: define PS2_TX_FILTER_EN.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} state_t;

    state_t        state;
    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_lvl;
    logic          clk_prev;
    logic          fe;
    logic [8:0]    shreg;
    logic [3:0]    idx;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          timeout;

    // Two-flop synchronizers; idle bus level is high, so reset to 1 to avoid a false edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

`ifdef PS2_TX_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    logic [FW-1:0] flt_cnt;

    // Accept a new PS2Clk level only after FILTER_LEN consecutive samples of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_lvl <= 1'b1;
            flt_cnt <= '0;
        end else if (clk_sync[1] == clk_lvl) begin
            flt_cnt <= '0;
        end else if (flt_cnt == FLT_LAST) begin
            clk_lvl <= clk_sync[1];
            flt_cnt <= '0;
        end else begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end
`else
    // Without the filter the synchronized level is used directly; FILTER_LEN has no effect
    assign clk_lvl = clk_sync[1] | (FILTER_LEN < 0);
`endif

    // Previous PS2Clk level for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) clk_prev <= 1'b1;
        else     clk_prev <= clk_lvl;
    end

    assign fe      = clk_prev & ~clk_lvl;
    assign timeout = tmo_cnt == TMO_LAST;

    // Handshake FSM: inhibit, request-to-send, shift on device falling edges, ack, bus idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            shreg       <= '0;
            idx         <= '0;
            inh_cnt     <= '0;
            tmo_cnt     <= '0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            tmo_cnt <= tmo_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (tx_start && !tx_done && !tx_err) begin
                        shreg      <= {~^tx_data, tx_data};
                        inh_cnt    <= '0;
                        ps2_clk_oe <= 1'b1;
                        tx_busy    <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    inh_cnt <= inh_cnt + 1'b1;
                    if (inh_cnt == INH_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= REQ;
                    end
                end
                REQ, SHIFT, ACK: begin
                    if (timeout) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_err      <= 1'b1;
                        tx_busy     <= 1'b0;
                        state       <= IDLE;
                    end else if (fe) begin
                        if (state == ACK) begin
                            if (data_sync[1]) begin
                                tx_err  <= 1'b1;
                                tx_busy <= 1'b0;
                                state   <= IDLE;
                            end else begin
                                state <= WAIT_IDLE;
                            end
                        end else if (state == SHIFT && idx == 4'd9) begin
                            ps2_data_oe <= 1'b0;
                            state       <= ACK;
                        end else begin
                            ps2_data_oe <= ~shreg[0];
                            shreg       <= {1'b1, shreg[8:1]};
                            idx         <= (state == REQ) ? 4'd1 : idx + 4'd1;
                            state       <= SHIFT;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (clk_sync[1] && data_sync[1]) begin
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: randomized scoreboard bench for ps2_tx with a behavioural PS/2 device model
module tb_ps2_tx;
    localparam int INH = 20;
    localparam int TMO = 3000;
    localparam int FLT = 4;

    typedef struct {
        logic [10:0] frame;
        bit          done;
        bit          chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tx_data = '0;
    logic        tx_start = 1'b0;
    logic        tx_busy, tx_done, tx_err;
    logic        ps2_clk_oe, ps2_data_oe;
    logic        ps2_clk_line, ps2_data_line;
    logic        dev_clk_low = 1'b0;
    logic        dev_data_low = 1'b0;
    logic [10:0] dev_frame = '0;
    int          dev_n = 0;
    int          dev_mode = 0;
    int          tests = 0;
    int          fails = 0;
    exp_t        q[$];
    exp_t        e;

    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLT)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
        .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame as the device should see it: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic send(input logic [7:0] d, input bit done, input bit chk);
        exp_t x;
        x.frame = frame_of(d);
        x.done  = done;
        x.chk   = chk;
        @(negedge clk);
        q.push_back(x);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s: no completion pulse within %0d cycles, %0d outstanding", name, n, q.size());
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Device model: on request-to-send, clocks 11 pulses (40-cycle period), samples on rises, acks
    initial forever begin
        @(posedge clk);
        if (!rst && ps2_clk_line && !ps2_data_line) begin
            dev_frame    = '0;
            dev_frame[0] = ps2_data_line;
            dev_n        = 1;
            if (dev_mode == 1) begin
                while (!ps2_data_line) @(posedge clk);
            end else begin
                repeat (10) @(posedge clk);
                for (int k = 1; k <= 11; k++) begin
                    dev_clk_low = 1'b1;
                    repeat (20) @(posedge clk);
                    dev_clk_low = 1'b0;
                    if (k <= 10) begin
                        dev_frame[dev_n] = ps2_data_line;
                        dev_n++;
                    end
                    if (k == 10 && dev_mode != 2) dev_data_low = 1'b1;
                    if (k == 11) dev_data_low = 1'b0;
                    if (k == 3 && dev_mode == 3) begin
                        repeat (8) @(posedge clk);
                        dev_clk_low = 1'b1;
                        repeat (2) @(posedge clk);
                        dev_clk_low = 1'b0;
                        repeat (10) @(posedge clk);
                    end else begin
                        repeat (20) @(posedge clk);
                    end
                end
            end
        end
    end

    // Monitor: every done/err pulse pops one expectation and checks outcome and received frame
    always @(negedge clk) begin
        if (tx_done || tx_err) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pulse: unexpected done=%0b err=%0b with nothing outstanding", tx_done, tx_err);
            end else begin
                e = q.pop_front();
                check("outcome {done,err}", {30'd0, tx_done, tx_err}, {30'd0, e.done, !e.done});
                check("busy at pulse", {31'd0, tx_busy}, 32'd0);
                if (e.chk) begin
                    check("device bit count", dev_n, 11);
                    check("device frame", {21'd0, dev_frame}, {21'd0, e.frame});
                end
            end
        end
    end

    initial begin
        int n;
        logic [7:0] r;
        repeat (3) @(negedge clk);
        check("reset outputs", {28'd0, tx_busy, tx_done, tx_err, ps2_clk_oe | ps2_data_oe}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: asynchronous reset in the middle of INHIBIT
        tx_data  = 8'hED;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (5) @(negedge clk);
        check("inhibit clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
        #2 rst = 1'b1;
        #1 check("async reset outputs", {29'd0, ps2_clk_oe, ps2_data_oe, tx_busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // 2: 0xED, inhibit length and busy
        send(8'hED, 1'b1, 1'b1);
        check("busy after accept", {31'd0, tx_busy}, 32'd1);
        n = 0;
        while (ps2_clk_oe && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("inhibit length", n, INH);
        wait_idle("send 0xED");

        // 3: 0xF4 with a mid-transfer start that must be ignored
        send(8'hF4, 1'b1, 1'b1);
        repeat (200) @(negedge clk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        n = 0;
        while (!tx_done && !tx_err && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("0xF4 completion seen", {31'd0, tx_done}, 32'd1);
        // start coinciding with the done pulse is ignored, the next cycle's start is accepted
        r = 8'($urandom);
        tx_data  = r;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("start on done ignored", {31'd0, tx_busy}, 32'd0);
        send(r, 1'b1, 1'b1);
        check("start after done accepted", {31'd0, tx_busy}, 32'd1);
        wait_idle("send after done");

        // 4: device never clocks -> timeout
        dev_mode = 1;
        send(8'($urandom), 1'b0, 1'b0);
        n = 0;
        while (ps2_clk_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!tx_err && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("timeout latency", n, TMO);
        check("timeout lines released", {29'd0, ps2_clk_oe, ps2_data_oe, tx_busy}, 32'd0);
        wait_idle("timeout");
        dev_mode = 0;

        // 5: device withholds the ack
        dev_mode = 2;
        send(8'($urandom), 1'b0, 1'b1);
        wait_idle("no ack");
        dev_mode = 0;
        repeat (50) @(negedge clk);

        // random bytes through the normal path
        for (int i = 0; i < 6; i++) begin
            send(8'($urandom), 1'b1, 1'b1);
            wait_idle("random byte");
        end

`ifdef PS2_TX_FILTER_EN
        // 6: short clock glitch during SHIFT is filtered out
        dev_mode = 3;
        send(8'hED, 1'b1, 1'b1);
        wait_idle("glitch 0xED");
        dev_mode = 0;
`endif

        check("scoreboard empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
